// File: rtl/npc_btb_unit.sv
// npc_btb_unit: fetch PC register plus a direct-mapped branch target buffer.
// Predicts taken branches and jumps at fetch, resolves the real next PC from
// the MEM-stage result, and redirects fetch (with a flush) on a mispredict
// or an exception.
//
// NPCOp encodings used on res_op_i:
//   3'd0 PLUS4, 3'd1 BRANCH, 3'd2 JUMP, 3'd3 JALR; any other value acts as PLUS4.
module npc_btb_unit #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_PC    = 32'h0000_0000,
  parameter logic [XLEN-1:0]   EXC_VEC     = 32'h0000_0100,
  parameter int                BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            exc_i,
  input  logic            res_valid_i,
  input  logic [2:0]      res_op_i,
  input  logic            res_taken_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [XLEN-1:0] res_imm_i,
  input  logic [XLEN-1:0] res_rs1_i,
  input  logic            res_pred_taken_i,
  input  logic [XLEN-1:0] res_pred_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            mispredict_o,
  output logic            flush_o
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JALR   = 3'd3;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // BTB storage
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_next;

  // Fetch-side lookup
  logic [IDX-1:0]   fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  // Resolution
  logic [XLEN-1:0]  seq_npc;
  logic [XLEN-1:0]  rel_npc;
  logic [XLEN-1:0]  jalr_sum;
  logic             act_taken;
  logic [XLEN-1:0]  act_npc;

  // Update side
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [1:0]       wr_ctr;

  assign fetch_idx = pc_q[IDX+1:2];
  assign fetch_tag = pc_q[XLEN-1:IDX+2];
  assign fetch_hit = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);

  assign pc_o          = pc_q;
  assign pred_taken_o  = fetch_hit && btb_ctr[fetch_idx][1];
  assign pred_target_o = fetch_hit ? btb_target[fetch_idx] : '0;

  assign seq_npc  = res_pc_i + PC_STEP;
  assign rel_npc  = res_pc_i + res_imm_i;
  assign jalr_sum = res_rs1_i + res_imm_i;

  // Work out where the resolved instruction really goes and whether it was taken
  always_comb begin
    act_taken = 1'b0;
    act_npc   = seq_npc;
    case (res_op_i)
      NPC_BRANCH: begin
        act_taken = res_taken_i;
        act_npc   = res_taken_i ? rel_npc : seq_npc;
      end
      NPC_JUMP: begin
        act_taken = 1'b1;
        act_npc   = rel_npc;
      end
      NPC_JALR: begin
        act_taken = 1'b1;
        act_npc   = {jalr_sum[XLEN-1:1], 1'b0};
      end
      NPC_PLUS4: begin
        act_taken = 1'b0;
        act_npc   = seq_npc;
      end
      default: begin
        act_taken = 1'b0;
        act_npc   = seq_npc;
      end
    endcase
  end

  assign mispredict_o = res_valid_i &&
                        ((act_taken != res_pred_taken_i) ||
                         (act_taken && (act_npc != res_pred_target_i)));
  assign flush_o      = mispredict_o || exc_i;

  // Next fetch PC: exception, then mispredict redirect, then stall, then prediction
  always_comb begin
    pc_next = pc_q + PC_STEP;
    if (exc_i) begin
      pc_next = EXC_VEC;
    end else if (mispredict_o) begin
      pc_next = act_npc;
    end else if (stall_i) begin
      pc_next = pc_q;
    end else if (pred_taken_o) begin
      pc_next = pred_target_o;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign upd_idx = res_pc_i[IDX+1:2];
  assign upd_tag = res_pc_i[XLEN-1:IDX+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  // Decide what (if anything) to write into the BTB entry of the resolved PC
  always_comb begin
    wr_en     = 1'b0;
    wr_tag    = upd_tag;
    wr_target = act_npc;
    wr_ctr    = 2'b10;
    if (res_valid_i && !exc_i) begin
      case (res_op_i)
        NPC_BRANCH: begin
          if (res_taken_i) begin
            wr_en = 1'b1;
            if (upd_hit) begin
              wr_ctr = (btb_ctr[upd_idx] == 2'b11) ? 2'b11 : btb_ctr[upd_idx] + 2'b01;
            end else begin
              wr_ctr = 2'b10;
            end
          end else if (upd_hit) begin
            wr_en     = 1'b1;
            wr_target = btb_target[upd_idx];
            wr_ctr    = (btb_ctr[upd_idx] == 2'b00) ? 2'b00 : btb_ctr[upd_idx] - 2'b01;
          end
        end
        NPC_JUMP: begin
          wr_en  = 1'b1;
          wr_ctr = 2'b11;
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  // BTB entry write; reset invalidates every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (wr_en) begin
      btb_valid[upd_idx]  <= 1'b1;
      btb_tag[upd_idx]    <= wr_tag;
      btb_target[upd_idx] <= wr_target;
      btb_ctr[upd_idx]    <= wr_ctr;
    end
  end

endmodule

// File: tb/tb_npc_btb_unit.sv
// tb_npc_btb_unit: directed walk through the main next-PC scenarios followed
// by randomized traffic, all compared against a behavioural model of the
// fetch PC and BTB held in plain arrays.
module tb_npc_btb_unit;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_0100;

  localparam logic [2:0] OP_PLUS4  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        exc_i;
  logic        res_valid_i;
  logic [2:0]  res_op_i;
  logic        res_taken_i;
  logic [31:0] res_pc_i;
  logic [31:0] res_imm_i;
  logic [31:0] res_rs1_i;
  logic        res_pred_taken_i;
  logic [31:0] res_pred_target_i;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        mispredict_o;
  logic        flush_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_pc;

  // Outputs observed during the most recent step
  logic        last_pt;
  logic [31:0] last_ptg;
  logic        last_mis;
  logic        last_flush;

  npc_btb_unit #(
    .XLEN(32),
    .RESET_PC(RESET_PC),
    .EXC_VEC(EXC_VEC),
    .BTB_ENTRIES(ENTRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .exc_i(exc_i),
    .res_valid_i(res_valid_i),
    .res_op_i(res_op_i),
    .res_taken_i(res_taken_i),
    .res_pc_i(res_pc_i),
    .res_imm_i(res_imm_i),
    .res_rs1_i(res_rs1_i),
    .res_pred_taken_i(res_pred_taken_i),
    .res_pred_target_i(res_pred_target_i),
    .pc_o(pc_o),
    .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o),
    .mispredict_o(mispredict_o),
    .flush_o(flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 0;
    end
    m_pc = RESET_PC;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model and DUT
  task automatic applyStimulus(input bit stall, input bit exc, input bit rv,
                               input logic [2:0] op, input bit taken,
                               input logic [31:0] rpc, input logic [31:0] imm,
                               input logic [31:0] rs1, input bit ptaken,
                               input logic [31:0] ptarget);
    bit          e_pt;
    logic [31:0] e_ptg;
    bit          e_taken;
    logic [31:0] e_npc;
    bit          e_mis;
    logic [31:0] next_pc;
    int          fi;
    int          ui;
    stall_i           = stall;
    exc_i             = exc;
    res_valid_i       = rv;
    res_op_i          = op;
    res_taken_i       = taken;
    res_pc_i          = rpc;
    res_imm_i         = imm;
    res_rs1_i         = rs1;
    res_pred_taken_i  = ptaken;
    res_pred_target_i = ptarget;
    #1;
    fi    = m_index(m_pc);
    e_pt  = m_hit(m_pc) && (m_ctr[fi] >= 2);
    e_ptg = m_hit(m_pc) ? m_target[fi] : 32'h0;
    if (op == OP_BRANCH) begin
      e_taken = taken;
      e_npc   = taken ? rpc + imm : rpc + 32'd4;
    end else if (op == OP_JUMP) begin
      e_taken = 1'b1;
      e_npc   = rpc + imm;
    end else if (op == OP_JALR) begin
      e_taken = 1'b1;
      e_npc   = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      e_taken = 1'b0;
      e_npc   = rpc + 32'd4;
    end
    e_mis = rv && ((e_taken != ptaken) || (e_taken && (e_npc != ptarget)));

    last_pt    = pred_taken_o;
    last_ptg   = pred_target_o;
    last_mis   = mispredict_o;
    last_flush = flush_o;
    checkOutput("pc", pc_o, m_pc);
    checkOutput("pred_taken", {31'b0, pred_taken_o}, {31'b0, e_pt});
    checkOutput("pred_target", pred_target_o, e_ptg);
    checkOutput("mispredict", {31'b0, mispredict_o}, {31'b0, e_mis});
    checkOutput("flush", {31'b0, flush_o}, {31'b0, (e_mis || exc)});

    if (exc)           next_pc = EXC_VEC;
    else if (e_mis)    next_pc = e_npc;
    else if (stall)    next_pc = m_pc;
    else if (e_pt)     next_pc = e_ptg;
    else               next_pc = m_pc + 32'd4;

    if (rv && !exc) begin
      ui = m_index(rpc);
      if (op == OP_BRANCH && taken) begin
        if (m_hit(rpc)) begin
          m_ctr[ui]    = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_target[ui] = e_npc;
        end else begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = m_tagof(rpc);
          m_target[ui] = e_npc;
          m_ctr[ui]    = 2;
        end
      end else if (op == OP_BRANCH && !taken) begin
        if (m_hit(rpc)) m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end else if (op == OP_JUMP) begin
        m_valid[ui]  = 1'b1;
        m_tag[ui]    = m_tagof(rpc);
        m_target[ui] = e_npc;
        m_ctr[ui]    = 3;
      end
    end
    @(posedge clk);
    m_pc = next_pc;
    @(negedge clk);
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, OP_PLUS4, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // Redirect fetch to target by resolving a PLUS4 at target-4 that claimed taken
  task automatic redirectTo(input logic [31:0] target);
    applyStimulus(0, 0, 1, OP_PLUS4, 0, target - 32'd4, 32'h0, 32'h0, 1, 32'hDEAD_0000);
  endtask

  initial begin
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    bit          r_pt;
    logic [31:0] r_ptg;

    rst               = 1'b1;
    stall_i           = 1'b0;
    exc_i             = 1'b0;
    res_valid_i       = 1'b0;
    res_op_i          = OP_PLUS4;
    res_taken_i       = 1'b0;
    res_pc_i          = '0;
    res_imm_i         = '0;
    res_rs1_i         = '0;
    res_pred_taken_i  = 1'b0;
    res_pred_target_i = '0;
    m_reset();
    #2;
    checkOutput("rst_pc", pc_o, RESET_PC);
    checkOutput("rst_pred_taken", {31'b0, pred_taken_o}, 32'h0);
    checkOutput("rst_pred_target", pred_target_o, 32'h0);
    checkOutput("rst_mispredict", {31'b0, mispredict_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from reset
    for (int k = 0; k < 4; k++) begin
      checkOutput("seq_pc", pc_o, 32'(k * 4));
      idleStep();
      checkOutput("seq_pred_taken", {31'b0, last_pt}, 32'h0);
    end

    // First taken branch at 0x10 mispredicts and allocates
    checkOutput("br_fetch_pc", pc_o, 32'h10);
    applyStimulus(0, 0, 1, OP_BRANCH, 1, 32'h10, 32'h20, 32'h0, 0, 32'h0);
    checkOutput("br_mis", {31'b0, last_mis}, 32'h1);
    checkOutput("br_flush", {31'b0, last_flush}, 32'h1);
    checkOutput("br_redirect_pc", pc_o, 32'h30);

    // Refetch 0x10: predicted taken to 0x30, correct resolve bumps ctr to 3
    redirectTo(32'h10);
    checkOutput("refetch_pc", pc_o, 32'h10);
    applyStimulus(0, 0, 1, OP_BRANCH, 1, 32'h10, 32'h20, 32'h0, 1, 32'h30);
    checkOutput("hit_pred_taken", {31'b0, last_pt}, 32'h1);
    checkOutput("hit_pred_target", last_ptg, 32'h30);
    checkOutput("hit_mis", {31'b0, last_mis}, 32'h0);
    checkOutput("hit_next_pc", pc_o, 32'h30);

    // Two not-taken resolves: 3->2->1, each redirecting to 0x14
    applyStimulus(0, 0, 1, OP_BRANCH, 0, 32'h10, 32'h20, 32'h0, 1, 32'h30);
    checkOutput("nt1_mis", {31'b0, last_mis}, 32'h1);
    checkOutput("nt1_pc", pc_o, 32'h14);
    applyStimulus(0, 0, 1, OP_BRANCH, 0, 32'h10, 32'h20, 32'h0, 1, 32'h30);
    checkOutput("nt2_pc", pc_o, 32'h14);
    redirectTo(32'h10);
    idleStep();
    checkOutput("weak_pred_taken", {31'b0, last_pt}, 32'h0);
    checkOutput("weak_pred_target", last_ptg, 32'h30);
    checkOutput("weak_next_pc", pc_o, 32'h14);

    // JALR clears bit 0 and never touches the BTB
    applyStimulus(0, 0, 1, OP_JALR, 0, 32'h50, 32'h4, 32'h1003, 0, 32'h0);
    checkOutput("jalr_pc", pc_o, 32'h1006);
    redirectTo(32'h50);
    idleStep();
    checkOutput("jalr_no_alloc", {31'b0, last_pt}, 32'h0);

    // Exception beats stall and mispredict and suppresses the BTB write
    applyStimulus(1, 1, 1, OP_BRANCH, 1, 32'h40, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("exc_mis", {31'b0, last_mis}, 32'h1);
    checkOutput("exc_flush", {31'b0, last_flush}, 32'h1);
    checkOutput("exc_pc", pc_o, EXC_VEC);
    redirectTo(32'h40);
    idleStep();
    checkOutput("exc_no_write_pt", {31'b0, last_pt}, 32'h0);
    checkOutput("exc_no_write_ptg", last_ptg, 32'h0);

    // PC wraps at the top of the address space
    applyStimulus(0, 0, 1, OP_JALR, 0, 32'h60, 32'h4, 32'hFFFF_FFF8, 0, 32'h0);
    checkOutput("wrap_setup_pc", pc_o, 32'hFFFF_FFFC);
    idleStep();
    checkOutput("wrap_pc", pc_o, 32'h0);

    // Reset in the middle of a redirecting jump wins at once
    applyStimulus(0, 0, 1, OP_JUMP, 0, 32'h20, 32'h40, 32'h0, 1, 32'h60);
    stall_i           = 1'b0;
    exc_i             = 1'b0;
    res_valid_i       = 1'b1;
    res_op_i          = OP_JUMP;
    res_pc_i          = 32'h24;
    res_imm_i         = 32'h80;
    res_pred_taken_i  = 1'b0;
    res_pred_target_i = 32'h0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_pc", pc_o, RESET_PC);
    checkOutput("midrst_pred_taken", {31'b0, pred_taken_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    m_reset();
    res_valid_i = 1'b0;
    rst         = 1'b0;
    redirectTo(32'h20);
    idleStep();
    checkOutput("midrst_cleared", {31'b0, last_pt}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      r_pc = 32'($urandom_range(0, 31)) * 32'd4;
      if ($urandom_range(0, 3) == 0) r_pc = r_pc + 32'h0000_1000;
      r_imm = 32'(int'($urandom_range(0, 63)) * 4 - 128);
      if ($urandom_range(0, 9) < 7) begin
        r_pt  = m_hit(r_pc) && (m_ctr[m_index(r_pc)] >= 2);
        r_ptg = m_hit(r_pc) ? m_target[m_index(r_pc)] : 32'h0;
      end else begin
        r_pt  = 1'($urandom_range(0, 1));
        r_ptg = $urandom;
      end
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), r_pc, r_imm, $urandom, r_pt, r_ptg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
